// File: rtl/issueq_free_list_pkg.sv
// ---------------------------------------------------------------------------
// issueq_free_list_pkg
// Shared sizing constants and types for the issue-queue free-entry pool.
//   SIZE_ISSUEQ      : issue queue entries (128)
//   SIZE_ISSUEQ_LOG  : entry index width (7)
//   ENTRY_PER_BLOCK  : entries per select block (32)
//   DISPATCH_WIDTH   : allocation lanes, one per block (4)
//   ISSUE_WIDTH      : release ports (4)
//   NUM_BLOCKS       : SIZE_ISSUEQ / ENTRY_PER_BLOCK, must equal DISPATCH_WIDTH
// ---------------------------------------------------------------------------
package issueq_free_list_pkg;

  localparam int SIZE_ISSUEQ         = 128;
  localparam int SIZE_ISSUEQ_LOG     = 7;
  localparam int ENTRY_PER_BLOCK     = 32;
  localparam int ENTRY_PER_BLOCK_LOG = 5;
  localparam int DISPATCH_WIDTH      = 4;
  localparam int ISSUE_WIDTH         = 4;
  localparam int NUM_BLOCKS          = SIZE_ISSUEQ / ENTRY_PER_BLOCK;
  // Upper index bits select the block, lower bits the entry inside it.
  localparam int BLOCK_SEL_W         = SIZE_ISSUEQ_LOG - ENTRY_PER_BLOCK_LOG;
  localparam int CNT_W               = SIZE_ISSUEQ_LOG + 1;

  typedef logic [SIZE_ISSUEQ_LOG-1:0]     iqIdx_t;
  typedef logic [CNT_W-1:0]               iqCnt_t;
  typedef logic [ENTRY_PER_BLOCK_LOG-1:0] blkIdx_t;

  // Number of set bits in a full-width entry mask.
  function automatic iqCnt_t popcount(input logic [SIZE_ISSUEQ-1:0] vec);
    iqCnt_t cnt;
    cnt = '0;
    for (int i = 0; i < SIZE_ISSUEQ; i++) begin
      cnt = cnt + iqCnt_t'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/issueq_block_select.sv
// ---------------------------------------------------------------------------
// issueq_block_select
// Finds the lowest-index free entry inside one select block.
//   blockVec   in  ENTRY_PER_BLOCK   free bits of the block (1 = free)
//   blockValid out 1                 block holds at least one free entry
//   lowIdx     out ENTRY_PER_BLOCK_LOG  local index of lowest free entry
//                                    (0 when the block is empty)
// ---------------------------------------------------------------------------
module issueq_block_select
  import issueq_free_list_pkg::*;
(
  input  logic [ENTRY_PER_BLOCK-1:0]     blockVec,
  output logic                           blockValid,
  output logic [ENTRY_PER_BLOCK_LOG-1:0] lowIdx
);

  assign blockValid = |blockVec;

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    lowIdx = '0;
    for (int i = ENTRY_PER_BLOCK - 1; i >= 0; i--) begin
      if (blockVec[i]) begin
        lowIdx = blkIdx_t'(i);
      end
    end
  end

endmodule

// File: rtl/issueq_free_list.sv
// ---------------------------------------------------------------------------
// issueq_free_list
// Free-entry pool for the issue queue. Offers one lowest-index free entry
// per block to dispatch and takes back entries released by issue.
//   clk              in  1            clock
//   reset            in  1            async active-high reset
//   flush_i          in  1            return every entry to the pool
//   dispatchValid_i  in  DISPATCH_WIDTH  per-lane allocation request
//   dispatchReady_o  out 1            every block has a free entry
//   allocIndex_o     out DISPATCH_WIDTH x SIZE_ISSUEQ_LOG  offered entries,
//                                     lane i at [i*7 +: 7]
//   issueValid_i     in  ISSUE_WIDTH  per-port release strobe
//   issueIndex_i     in  ISSUE_WIDTH x SIZE_ISSUEQ_LOG  entries to release,
//                                     port k at [k*7 +: 7]
//   freeCnt_o        out SIZE_ISSUEQ_LOG+1  registered free-entry count
//   freeErr_o        out 1            sticky: release of an already-free
//                                     entry (incl. duplicate release ports)
//
// Handshake: lane i allocates in a cycle exactly when dispatchValid_i[i] and
// dispatchReady_o are both high at the clock edge; it then consumes the entry
// shown on allocIndex_o for lane i. With ready low, requests are ignored and
// dispatch holds. Offers depend only on registered state, never on the
// same-cycle valid, so there is no valid->ready combinational path.
// ---------------------------------------------------------------------------
module issueq_free_list
  import issueq_free_list_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush_i,
  input  logic [DISPATCH_WIDTH-1:0]                 dispatchValid_i,
  output logic                                      dispatchReady_o,
  output logic [DISPATCH_WIDTH*SIZE_ISSUEQ_LOG-1:0] allocIndex_o,
  input  logic [ISSUE_WIDTH-1:0]                    issueValid_i,
  input  logic [ISSUE_WIDTH*SIZE_ISSUEQ_LOG-1:0]    issueIndex_i,
  output logic [SIZE_ISSUEQ_LOG:0]                  freeCnt_o,
  output logic                                      freeErr_o
);

  logic [SIZE_ISSUEQ-1:0] freeVec;
  iqCnt_t                 freeCnt;
  logic                   freeErr;

  logic [NUM_BLOCKS-1:0]          blkValid;
  logic [ENTRY_PER_BLOCK_LOG-1:0] blkLow   [NUM_BLOCKS];
  iqIdx_t                         offerIdx [NUM_BLOCKS];

  // ---- offer side: one select per block --------------------------------
  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : gBlock
    issueq_block_select uSel (
      .blockVec   (freeVec[b*ENTRY_PER_BLOCK +: ENTRY_PER_BLOCK]),
      .blockValid (blkValid[b]),
      .lowIdx     (blkLow[b])
    );

    // An empty block offers index 0 rather than its base.
    assign offerIdx[b] = blkValid[b] ? {BLOCK_SEL_W'(b), blkLow[b]} : '0;
    assign allocIndex_o[b*SIZE_ISSUEQ_LOG +: SIZE_ISSUEQ_LOG] = offerIdx[b];
  end

  // A single empty block stalls all lanes, even if others still have room.
  assign dispatchReady_o = &blkValid;

  // ---- next-state masks ------------------------------------------------
  logic [SIZE_ISSUEQ-1:0] clearMask;
  logic [SIZE_ISSUEQ-1:0] setMask;
  logic [SIZE_ISSUEQ-1:0] effClear;
  logic [SIZE_ISSUEQ-1:0] newFree;
  logic [SIZE_ISSUEQ-1:0] freeVecNext;
  iqCnt_t                 freeCntNext;
  logic                   relErr;
  iqIdx_t                 relIdx;

  always_comb begin
    clearMask = '0;
    setMask   = '0;
    relErr    = 1'b0;
    relIdx    = '0;

    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (dispatchValid_i[i] && dispatchReady_o) begin
        clearMask[offerIdx[i]] = 1'b1;
      end
    end

    // Checking setMask as well as freeVec catches the same index on two
    // ports in one cycle; that entry is then counted only once.
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (issueValid_i[k]) begin
        relIdx = issueIndex_i[k*SIZE_ISSUEQ_LOG +: SIZE_ISSUEQ_LOG];
        if (freeVec[relIdx] || setMask[relIdx]) begin
          relErr = 1'b1;
        end
        setMask[relIdx] = 1'b1;
      end
    end

    // Release wins over a same-cycle allocation of the same entry; such a
    // release always targets a free (offered) entry, so relErr is raised
    // above and the allocation is dropped from the count here.
    effClear    = clearMask & ~setMask;
    newFree     = setMask & ~freeVec;
    freeVecNext = (freeVec & ~clearMask) | setMask;
    freeCntNext = freeCnt + popcount(newFree) - popcount(effClear);
  end

  // ---- state -----------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freeVec <= '1;
      freeCnt <= iqCnt_t'(SIZE_ISSUEQ);
      freeErr <= 1'b0;
    end else if (flush_i) begin
      // Flush drops any same-cycle alloc/release, including its error.
      freeVec <= '1;
      freeCnt <= iqCnt_t'(SIZE_ISSUEQ);
    end else begin
      freeVec <= freeVecNext;
      freeCnt <= freeCntNext;
      freeErr <= freeErr | relErr;
    end
  end

  assign freeCnt_o = freeCnt;
  assign freeErr_o = freeErr;

endmodule

// File: tb/tb_issueq_free_list.sv
// ---------------------------------------------------------------------------
// tb_issueq_free_list
// Directed bench for issueq_free_list: a table of single-cycle vectors with
// hand-computed results, followed by multi-cycle sequences for the drain,
// stall, duplicate-release and mid-burst reset cases.
// ---------------------------------------------------------------------------
module tb_issueq_free_list;
  import issueq_free_list_pkg::*;

  // ---- clock / reset ---------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                                      flush_i;
  logic [DISPATCH_WIDTH-1:0]                 dispatchValid_i;
  logic                                      dispatchReady_o;
  logic [DISPATCH_WIDTH*SIZE_ISSUEQ_LOG-1:0] allocIndex_o;
  logic [ISSUE_WIDTH-1:0]                    issueValid_i;
  logic [ISSUE_WIDTH*SIZE_ISSUEQ_LOG-1:0]    issueIndex_i;
  logic [SIZE_ISSUEQ_LOG:0]                  freeCnt_o;
  logic                                      freeErr_o;

  issueq_free_list dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush_i),
    .dispatchValid_i (dispatchValid_i),
    .dispatchReady_o (dispatchReady_o),
    .allocIndex_o    (allocIndex_o),
    .issueValid_i    (issueValid_i),
    .issueIndex_i    (issueIndex_i),
    .freeCnt_o       (freeCnt_o),
    .freeErr_o       (freeErr_o)
  );

  // ---- scoreboard ------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [SIZE_ISSUEQ_LOG-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [SIZE_ISSUEQ_LOG-1:0] lane_idx(input int l);
    return allocIndex_o[l*SIZE_ISSUEQ_LOG +: SIZE_ISSUEQ_LOG];
  endfunction

  task automatic check_offer(input string tag, input int a0, input int a1,
                             input int a2, input int a3);
    check($sformatf("%s alloc0", tag), 32'(lane_idx(0)), a0);
    check($sformatf("%s alloc1", tag), 32'(lane_idx(1)), a1);
    check($sformatf("%s alloc2", tag), 32'(lane_idx(2)), a2);
    check($sformatf("%s alloc3", tag), 32'(lane_idx(3)), a3);
  endtask

  task automatic check_state(input string tag, input logic rdy,
                             input int cnt, input logic err);
    check($sformatf("%s ready", tag), 32'(dispatchReady_o), 32'(rdy));
    check($sformatf("%s freeCnt", tag), 32'(freeCnt_o), cnt);
    check($sformatf("%s freeErr", tag), 32'(freeErr_o), 32'(err));
  endtask

  // ---- driver ----------------------------------------------------------
  task automatic drive(input logic fl, input logic [3:0] dv,
                       input logic [3:0] iv, input iqIdx_t p0,
                       input iqIdx_t p1, input iqIdx_t p2, input iqIdx_t p3);
    flush_i         = fl;
    dispatchValid_i = dv;
    issueValid_i    = iv;
    issueIndex_i    = {p3, p2, p1, p0};
  endtask

  // Outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
    reset = 1'b1;
    #1;
    check_state("reset", 1'b1, 128, 1'b0);
    check_offer("reset", 0, 32, 64, 96);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // ---- vector table ----------------------------------------------------
  typedef struct {
    logic       fl;
    logic [3:0] dv;
    logic [3:0] iv;
    iqIdx_t     p0, p1, p2, p3;
    logic       rdy;
    int         a0, a1, a2, a3;
    int         cnt;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic fl, input logic [3:0] dv,
                         input logic [3:0] iv, input iqIdx_t p0,
                         input iqIdx_t p1, input iqIdx_t p2, input iqIdx_t p3,
                         input logic rdy, input int a0, input int a1,
                         input int a2, input int a3, input int cnt,
                         input logic err);
    vec_t v;
    v.fl = fl; v.dv = dv; v.iv = iv;
    v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
    v.rdy = rdy; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
    v.cnt = cnt; v.err = err;
    vecs.push_back(v);
  endtask

  // ---- test ------------------------------------------------------------
  initial begin
    // Expected values below are the state after each vector's clock edge,
    // starting from reset.
    //      fl  dv     iv     p0  p1  p2 p3  rdy a0 a1  a2  a3  cnt err
    add_vec(0, 4'b0001, 4'b0000, 0, 0, 0, 0, 1, 1, 32, 64, 96, 127, 0);
    add_vec(0, 4'b0110, 4'b0000, 0, 0, 0, 0, 1, 1, 33, 65, 96, 125, 0);
    // release busy entry 0
    add_vec(0, 4'b0000, 4'b0001, 0, 0, 0, 0, 1, 0, 33, 65, 96, 126, 0);
    // all lanes take 0,33,65,96
    add_vec(0, 4'b1111, 4'b0000, 0, 0, 0, 0, 1, 1, 34, 66, 97, 122, 0);
    // release busy 33 and already-free 5
    add_vec(0, 4'b0000, 4'b0101, 33, 0, 5, 0, 1, 1, 33, 66, 97, 123, 1);
    // lane1's offered 33 released same cycle: release wins, 3 lanes count
    add_vec(0, 4'b1111, 4'b0010, 0, 33, 0, 0, 1, 2, 33, 67, 98, 120, 1);
    // flush overrides alloc on lanes 0,1 and release of busy 0,32
    add_vec(1, 4'b0011, 4'b0011, 0, 32, 0, 0, 1, 0, 32, 64, 96, 128, 1);

    reset = 1'b1;
    drive(1'b0, 4'b0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
    #12;
    do_reset();

    foreach (vecs[n]) begin
      drive(vecs[n].fl, vecs[n].dv, vecs[n].iv,
            vecs[n].p0, vecs[n].p1, vecs[n].p2, vecs[n].p3);
      tick();
      check_state($sformatf("vec%0d", n), vecs[n].rdy, vecs[n].cnt,
                  vecs[n].err);
      check_offer($sformatf("vec%0d", n),
                  vecs[n].a0, vecs[n].a1, vecs[n].a2, vecs[n].a3);
    end

    // Reset clears the sticky error.
    do_reset();

    // Drain: all lanes every cycle for 32 cycles, offers ascend per block.
    for (int c = 0; c < ENTRY_PER_BLOCK; c++) begin
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        exp_q.push_back(SIZE_ISSUEQ_LOG'(l * ENTRY_PER_BLOCK + c));
      end
    end
    drive(1'b0, 4'b1111, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
    for (int c = 0; c < ENTRY_PER_BLOCK; c++) begin
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        check($sformatf("drain c%0d alloc%0d", c, l), 32'(lane_idx(l)),
              32'(exp_q.pop_front()));
      end
      check($sformatf("drain c%0d ready", c), 32'(dispatchReady_o), 1);
      tick();
    end
    check_state("drained", 1'b0, 0, 1'b0);
    check_offer("drained", 0, 0, 0, 0);

    // Requests while not ready are ignored.
    tick();
    check_state("stall", 1'b0, 0, 1'b0);

    // Three blocks get an entry back, block 3 stays empty: still stalled.
    drive(1'b0, 4'b0000, 4'b0111, 7'd5, 7'd40, 7'd70, 7'd0);
    tick();
    check_state("partial", 1'b0, 3, 1'b0);
    check_offer("partial", 5, 40, 70, 0);

    drive(1'b0, 4'b0000, 4'b0001, 7'd100, 7'd0, 7'd0, 7'd0);
    tick();
    check_state("refill", 1'b1, 4, 1'b0);
    check_offer("refill", 5, 40, 70, 100);

    // Lane 0 takes 5, emptying block 0 again.
    drive(1'b0, 4'b0001, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    tick();
    check_state("take5", 1'b0, 3, 1'b0);
    check_offer("take5", 0, 40, 70, 100);

    // Same busy index on two ports: counted once, error set.
    drive(1'b0, 4'b0000, 4'b0011, 7'd5, 7'd5, 7'd0, 7'd0);
    tick();
    check_state("dup", 1'b1, 4, 1'b1);
    check_offer("dup", 5, 40, 70, 100);

    drive(1'b0, 4'b0000, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    tick();
    check_state("sticky", 1'b1, 4, 1'b1);

    // Reset in the middle of an allocation burst.
    do_reset();
    drive(1'b0, 4'b1111, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
    repeat (17) tick();
    check_state("burst", 1'b1, 60, 1'b0);
    check_offer("burst", 17, 49, 81, 113);
    #2;
    reset = 1'b1;
    #1;
    check_state("midreset", 1'b1, 128, 1'b0);
    check_offer("midreset", 0, 32, 64, 96);
    drive(1'b0, 4'b0, 4'b0, 7'd0, 7'd0, 7'd0, 7'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_state("idle", 1'b1, 128, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
